// File: rtl/gauss_frame_writer.sv
// Frame write-back for the Gaussian window path: pads the top and bottom
// borders, forwards window-centre results in raster order (substituting PAD
// on edge columns), then flags the frame as complete.
module gauss_frame_writer #(
  parameter int            IMG_W  = 512,
  parameter int            IMG_H  = 512,
  parameter int            BORDER = 5,
  parameter int            DW     = 8,
  parameter logic [DW-1:0] PAD    = '0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          din_valid_i,
  input  logic [DW-1:0] din_i,
  output logic          wr_en_o,
  output logic [20:0]   wr_addr_o,
  output logic [DW-1:0] wr_data_o,
  output logic          complete_o,
  output logic          err_o
);

  localparam int AW      = 21;
  localparam int CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int HEAD_I  = BORDER * IMG_W + BORDER;
  localparam int TOTAL_I = IMG_W * IMG_H;

  // Address of the last write in each phase; BORDER is assumed >= 1.
  localparam logic [AW-1:0] TOP_LAST = AW'(HEAD_I - 1);
  localparam logic [AW-1:0] STR_LAST = AW'(TOTAL_I - HEAD_I - 1);
  localparam logic [AW-1:0] BOT_LAST = AW'(TOTAL_I - 1);

  // Column of the first stream position; elaboration-time only, no divider.
  localparam logic [CW-1:0] COL0     = CW'(HEAD_I % IMG_W);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(IMG_W - BORDER);

  typedef enum logic [2:0] {IDLE, FILL_TOP, STREAM, FILL_BOT, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pos_q, pos_d;        // next address to be written
  logic [CW-1:0] col_q, col_d;        // column of pos_q while streaming
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          complete_q, complete_d;
  logic          err_q, err_d;

  logic          pad_col;
  assign pad_col = (col_q < COL_LO) || (col_q >= COL_HI);

  // State, counters and registered outputs; async clear returns all to idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      col_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      complete_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      col_q      <= col_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      complete_q <= complete_d;
      err_q      <= err_d;
    end
  end

  // Next-state and write generation for each frame phase.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    col_d      = col_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    complete_d = complete_q;
    // A beat outside STREAM is dropped and latched as an error.
    err_d      = err_q | (din_valid_i && (state_q != STREAM));

    case (state_q)
      IDLE: begin
        state_d = FILL_TOP;
      end
      FILL_TOP: begin
        wr_en_d   = 1'b1;
        wr_addr_d = pos_q;
        wr_data_d = PAD;
        pos_d     = pos_q + AW'(1);
        if (pos_q == TOP_LAST) begin
          state_d = STREAM;
          col_d   = COL0;
        end
      end
      STREAM: begin
        if (din_valid_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = pos_q;
          wr_data_d = pad_col ? PAD : din_i;
          pos_d     = pos_q + AW'(1);
          col_d     = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
          if (pos_q == STR_LAST) state_d = FILL_BOT;
        end
      end
      FILL_BOT: begin
        wr_en_d   = 1'b1;
        wr_addr_d = pos_q;
        wr_data_d = PAD;
        pos_d     = pos_q + AW'(1);
        if (pos_q == BOT_LAST) state_d = DONE;
      end
      DONE: begin
        complete_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign complete_o = complete_q;
  assign err_o      = err_q;

endmodule
